actor_move_ctrl: RTL
====================

# actor_move_ctrl

Parametrised movement controller for the player and enemy sprites on the Bomberman playfield. It latches direction requests and wall/column collisions during a video frame. Once per `startOfFrame` it resolves them into a new fixed-point position and outputs the sprite top-left corner to the object drawers and hit-detection logic. Compared with the earlier player mover, it adds:
- a four-entry speed table;
- per-axis collision rollback;
- grid-alignment ("corner slide") assist;
- freeze;
- facing and moving outputs for sprite animation.

## Interface
Parameters:
- `INITIAL_X`, 15: spawn X in pixels.
- `INITIAL_Y`, 48: spawn Y in pixels.
- `OBJ_W`, 32: sprite width in pixels.
- `OBJ_H`, 32: sprite height in pixels.
- `FRAME_LEFT`, 15: left limit of top-left X, in pixels.
- `FRAME_RIGHT`, 623: right edge; the limit is `FRAME_RIGHT-OBJ_W`.
- `FRAME_TOP`, 48: top limit of top-left Y, in pixels.
- `FRAME_BOTTOM`, 464: bottom edge; the limit is `FRAME_BOTTOM-OBJ_H`.
- `FP_SHIFT`, 6: fixed-point fraction bits (multiplier is 2^FP_SHIFT).
- `SPEED0`..`SPEED3`, 64/112/160/208: step per frame in fixed-point units.
- `TILE`, 32: grid pitch in pixels; must be a power of 2.
- `ALIGN_TOL`, 8: grid-assist capture distance in pixels; must be less than TILE/2.

Ports:
- `clk` in 1: system clock.
- `resetN` in 1: asynchronous, active-low reset.
- `startOfFrame` in 1: one-cycle pulse per frame.
- `up_direction_key`, `down_direction_key`, `left_direction_key`, `right_direction_key` in 1 each: movement requests.
- `collision` in 1: the sprite overlaps a wall or column this pixel.
- `HitEdgeCode` in 4: overlap edge. LEFT=1000, TOP=0100, RIGHT=0010, BOTTOM=0001.
- `speed_level` in 2: index into the speed table.
- `game_on` in 1: run enable.
- `freeze` in 1: suppresses movement for the frame.
- `topLeftX`, `topLeftY` out signed 11: pixel position.
- `current_speed_level` out 2: speed index in use.
- `facing` out 2: 0=down, 1=up, 2=left, 3=right.
- `moving` out 1: the last step changed the position.

## Operation
Internal state:
- Xpos, Ypos: signed 32-bit fixed-point position.
- prevX, prevY: position before the last step.
- req[3:0]: latched direction requests.
- hit_reg[3:0]: latched collision edges.

State machine, states IDLE → COLLECT → RESOLVE → STEP → COLLECT.

IDLE:
- Xpos=INITIAL_X<<FP_SHIFT and Ypos=INITIAL_Y<<FP_SHIFT; prev equals pos.
- req=0, hit_reg=0, facing=0, moving=0.
- If `game_on` is high, go to COLLECT.

COLLECT:
- Each key ORs into req.
- While `collision` is high, HitEdgeCode ORs into hit_reg. Edges accumulate over the whole frame; this is not first-hit-only.
- On `startOfFrame`, go to RESOLVE.

RESOLVE computes dx and dy, using speed S = SPEEDn[current_speed_level]:
- Opposing requests (up and down, or left and right) cancel on that axis.
- If both axes remain requested, vertical wins.
- Axis move is ±S. facing updates to the winning direction and is held when there is no move.
- Rollback: if hit_reg has TOP or BOTTOM, Ypos is restored to prevY. If it has LEFT or RIGHT, Xpos is restored to prevX. A move into a hit edge is zeroed (TOP blocks up, BOTTOM blocks down, LEFT blocks left, RIGHT blocks right).
- Grid assist on a horizontal move:
  - offY = (Ypos − FRAME_TOP<<FP_SHIFT) mod (TILE<<FP_SHIFT).
  - If 0 < offY ≤ ALIGN_TOL<<FP_SHIFT, then dy = −min(S, offY).
  - If offY ≥ (TILE−ALIGN_TOL)<<FP_SHIFT, then dy = +min(S, (TILE<<FP_SHIFT)−offY).
  - A vertical move applies the same rule to X, relative to FRAME_LEFT.
- If `freeze` is high, dx=dy=0, with no rollback and no assist.
- req and hit_reg clear.

STEP:
- prev is set to pos.
- pos = clamp(pos+d), with limits in fixed point: X in [FRAME_LEFT, FRAME_RIGHT−OBJ_W]<<FP_SHIFT and Y in [FRAME_TOP, FRAME_BOTTOM−OBJ_H]<<FP_SHIFT.
- moving = (new pos ≠ old pos).
- current_speed_level is set to speed_level.
- If `game_on` is low, go to IDLE; otherwise go to COLLECT.

Outputs:
- `topLeftX = Xpos>>>FP_SHIFT`; `topLeftY` likewise (arithmetic shift, truncated).
- All outputs are registered or derived directly from registers.

## Timing
- Reset values:
  - State=IDLE.
  - Xpos=INITIAL_X<<FP_SHIFT and Ypos=INITIAL_Y<<FP_SHIFT, so topLeftX=15 and topLeftY=48 at default parameters.
  - current_speed_level=0, facing=0, moving=0.
- Reset asserted mid-frame drops to IDLE immediately, discarding req and hit_reg.
- The pulse is sampled in COLLECT at cycle T. RESOLVE runs at T+1 and STEP at T+2. The new position is visible at T+3.
- Rollback writes pos at T+1, so topLeftX/Y may show the rolled-back value for one cycle before STEP.
- `startOfFrame`, keys and collision arriving during RESOLVE or STEP are ignored.
- A speed_level change takes effect on the frame after the next step, because the speed used in RESOLVE is the one registered in the previous STEP.
- When `game_on` goes low, the current step still completes; the reset to spawn happens on the IDLE cycle.

## Test plan
Defaults throughout (FP_SHIFT=6, speeds 64/112/160/208).
- **Spawn and single step:** reset, `game_on`=1, right held across one frame → topLeftX 15→16 at T+3; facing=3, moving=1.
- **Speed change:** right held, speed_level=2 → first frame +1 px (X=1024). Following frames: Xpos 1184 (X=18), then 1344 (X=21). current_speed_level=2 after the first STEP.
- **Simultaneous keys:**
  - Up and down held → Y unchanged, moving=0.
  - Up and right held → only Y moves.
  - Up held at Y=48 → clamps at 48, moving=0.
- **Collision rollback:** right for 2 frames (X 15→16→17). Then collision with HitEdgeCode=0010 while right is held → X=16 (rolled back), no further right step; Y unaffected.
- **Grid assist:** Y=50 px, right pressed, level 0 → X+1 and Y=49. Next frame → Y=48. At Y=60 (offset 12, above tolerance) → Y unchanged.
- **Freeze, drop and reset:**
  - `freeze` with keys held → no change.
  - `game_on` dropped → position returns to (15,48).
  - resetN pulse during COLLECT with latched hits → next frame behaves as a clean spawn.

Source files
------------

// File: rtl/actor_move_ctrl.sv
// Frame-synchronous movement controller for playfield sprites. Latches keys and collision edges
// during a frame, then resolves them into a clamped fixed-point step with rollback and grid assist.
module actor_move_ctrl #(
    parameter int INITIAL_X    = 15,
    parameter int INITIAL_Y    = 48,
    parameter int OBJ_W        = 32,
    parameter int OBJ_H        = 32,
    parameter int FRAME_LEFT   = 15,
    parameter int FRAME_RIGHT  = 623,
    parameter int FRAME_TOP    = 48,
    parameter int FRAME_BOTTOM = 464,
    parameter int FP_SHIFT     = 6,
    parameter int SPEED0       = 64,
    parameter int SPEED1       = 112,
    parameter int SPEED2       = 160,
    parameter int SPEED3       = 208,
    parameter int TILE         = 32,
    parameter int ALIGN_TOL    = 8
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic               up_direction_key,
    input  logic               down_direction_key,
    input  logic               left_direction_key,
    input  logic               right_direction_key,
    input  logic               collision,
    input  logic [3:0]         HitEdgeCode,
    input  logic [1:0]         speed_level,
    input  logic               game_on,
    input  logic               freeze,
    output logic signed [10:0] topLeftX,
    output logic signed [10:0] topLeftY,
    output logic [1:0]         current_speed_level,
    output logic [1:0]         facing,
    output logic               moving
);

    localparam int SpawnX  = INITIAL_X << FP_SHIFT;
    localparam int SpawnY  = INITIAL_Y << FP_SHIFT;
    localparam int XMin    = FRAME_LEFT << FP_SHIFT;
    localparam int XMax    = (FRAME_RIGHT - OBJ_W) << FP_SHIFT;
    localparam int YMin    = FRAME_TOP << FP_SHIFT;
    localparam int YMax    = (FRAME_BOTTOM - OBJ_H) << FP_SHIFT;
    localparam int TileFp  = TILE << FP_SHIFT;
    localparam int TolFp   = ALIGN_TOL << FP_SHIFT;

    typedef enum logic [1:0] {StIdle, StCollect, StResolve, StStep} state_e;

    state_e             r_state, w_state_nxt;
    logic signed [31:0] r_xpos, r_ypos, r_prev_x, r_prev_y, r_dx, r_dy;
    logic [3:0]         r_req;  // {right, left, down, up}
    logic [3:0]         r_hit;  // {LEFT, TOP, RIGHT, BOTTOM}
    logic [1:0]         r_facing, r_speed_lvl;
    logic               r_moving;

    logic signed [31:0] w_speed, w_xbase, w_ybase, w_offx, w_offy, w_dx, w_dy;
    logic signed [31:0] w_sumx, w_sumy, w_newx, w_newy;
    logic [1:0]         w_facing;
    logic               w_roll_x, w_roll_y, w_v_req, w_h_req;

    // Pull toward the nearest grid line when within tolerance, never overshooting it.
    function automatic logic signed [31:0] f_assist(input logic signed [31:0] off,
                                                    input logic signed [31:0] s);
        logic signed [31:0] rem;
        rem = TileFp - off;
        if (off != 0 && off <= TolFp) begin
            return (s < off) ? -s : -off;
        end else if (off >= TileFp - TolFp) begin
            return (s < rem) ? s : rem;
        end
        return '0;
    endfunction

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            StIdle:    if (game_on) w_state_nxt = StCollect;
            StCollect: if (startOfFrame) w_state_nxt = StResolve;
            StResolve: w_state_nxt = StStep;
            StStep:    w_state_nxt = game_on ? StCollect : StIdle;
            default:   w_state_nxt = StIdle;
        endcase
    end

    always_comb begin
        case (r_speed_lvl)
            2'd0:    w_speed = SPEED0;
            2'd1:    w_speed = SPEED1;
            2'd2:    w_speed = SPEED2;
            default: w_speed = SPEED3;
        endcase
        w_roll_x = !freeze && (r_hit[3] || r_hit[1]);
        w_roll_y = !freeze && (r_hit[2] || r_hit[0]);
        w_xbase  = w_roll_x ? r_prev_x : r_xpos;
        w_ybase  = w_roll_y ? r_prev_y : r_ypos;
        // TILE is a power of two, so masking gives a non-negative modulo.
        w_offx   = (w_xbase - XMin) & (TileFp - 1);
        w_offy   = (w_ybase - YMin) & (TileFp - 1);
        w_v_req  = r_req[0] ^ r_req[1];
        w_h_req  = r_req[2] ^ r_req[3];
        w_dx     = '0;
        w_dy     = '0;
        w_facing = r_facing;
        if (!freeze) begin
            if (w_v_req) begin
                w_facing = r_req[0] ? 2'd1 : 2'd0;
                if (r_req[0] && !r_hit[2]) begin
                    w_dy = -w_speed;
                end else if (r_req[1] && !r_hit[0]) begin
                    w_dy = w_speed;
                end
                if (w_dy != 0) w_dx = f_assist(w_offx, w_speed);
            end else if (w_h_req) begin
                w_facing = r_req[2] ? 2'd2 : 2'd3;
                if (r_req[2] && !r_hit[3]) begin
                    w_dx = -w_speed;
                end else if (r_req[3] && !r_hit[1]) begin
                    w_dx = w_speed;
                end
                if (w_dx != 0) w_dy = f_assist(w_offy, w_speed);
            end
        end
    end

    always_comb begin
        w_sumx = r_xpos + r_dx;
        w_sumy = r_ypos + r_dy;
        w_newx = (w_sumx < XMin) ? XMin : ((w_sumx > XMax) ? XMax : w_sumx);
        w_newy = (w_sumy < YMin) ? YMin : ((w_sumy > YMax) ? YMax : w_sumy);
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_xpos      <= SpawnX;
            r_ypos      <= SpawnY;
            r_prev_x    <= SpawnX;
            r_prev_y    <= SpawnY;
            r_dx        <= '0;
            r_dy        <= '0;
            r_req       <= '0;
            r_hit       <= '0;
            r_facing    <= '0;
            r_moving    <= 1'b0;
            r_speed_lvl <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    r_xpos   <= SpawnX;
                    r_ypos   <= SpawnY;
                    r_prev_x <= SpawnX;
                    r_prev_y <= SpawnY;
                    r_dx     <= '0;
                    r_dy     <= '0;
                    r_req    <= '0;
                    r_hit    <= '0;
                    r_facing <= '0;
                    r_moving <= 1'b0;
                end
                StCollect: begin
                    r_req <= r_req | {right_direction_key, left_direction_key,
                                      down_direction_key, up_direction_key};
                    if (collision) r_hit <= r_hit | HitEdgeCode;
                end
                StResolve: begin
                    r_xpos   <= w_xbase;
                    r_ypos   <= w_ybase;
                    r_dx     <= w_dx;
                    r_dy     <= w_dy;
                    r_facing <= w_facing;
                    r_req    <= '0;
                    r_hit    <= '0;
                end
                StStep: begin
                    r_prev_x    <= r_xpos;
                    r_prev_y    <= r_ypos;
                    r_xpos      <= w_newx;
                    r_ypos      <= w_newy;
                    r_moving    <= (w_newx != r_xpos) || (w_newy != r_ypos);
                    r_speed_lvl <= speed_level;
                end
                default: ;
            endcase
        end
    end

    // Bit slice equals the truncated arithmetic shift for an 11-bit result.
    assign topLeftX            = r_xpos[FP_SHIFT +: 11];
    assign topLeftY            = r_ypos[FP_SHIFT +: 11];
    assign current_speed_level = r_speed_lvl;
    assign facing              = r_facing;
    assign moving              = r_moving;

endmodule
